// File: rtl/mewb_if.sv
// mewb_if: MEM->WB stage handshake and payload bundle (MEM side *m, WB side *w, plus flush)
interface mewb_if #(parameter int XLEN = 32, parameter int REGW = 5, parameter int RSLTW = 2) ();
  logic flush;
  logic validm, readym, regWrtm, memWrtm;
  logic [RSLTW-1:0] rsltSrcm;
  logic [XLEN-1:0] readDm, pc4m, ujWrtBckm;
  logic [REGW-1:0] rdm;
  logic validw, readyw, regWrtw, memWrtw;
  logic [RSLTW-1:0] rsltSrcw;
  logic [XLEN-1:0] readDw, pc4w, ujWrtBckw, wbDataw;
  logic [REGW-1:0] rdw;
  modport slave (
    input flush, validm, regWrtm, memWrtm, rsltSrcm, readDm, pc4m, ujWrtBckm, rdm, readyw,
    output readym, validw, regWrtw, memWrtw, rsltSrcw, readDw, pc4w, ujWrtBckw, rdw, wbDataw
  );
  modport master (
    output flush, validm, regWrtm, memWrtm, rsltSrcm, readDm, pc4m, ujWrtBckm, rdm, readyw,
    input readym, validw, regWrtw, memWrtw, rsltSrcw, readDw, pc4w, ujWrtBckw, rdw, wbDataw
  );
endinterface

// File: rtl/mewb_stage.sv
// mewb_stage: two-entry elastic MEM->WB stage with writeback mux; MEWB_RETIRE_CNT_EN adds a 64-bit retire counter
module mewb_stage #(parameter int XLEN = 32, parameter int REGW = 5, parameter int RSLTW = 2) (
  input logic clk,
  input logic rst,
  mewb_if.slave bus
`ifdef MEWB_RETIRE_CNT_EN
  , output logic [63:0] retireCnt
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic regwrt;
    logic memwrt;
    logic [RSLTW-1:0] rslt;
    logic [XLEN-1:0] readd;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] ujw;
    logic [REGW-1:0] rd;
  } entry_t;
  state_t state, nxt;
  entry_t h, s, in_e;
  logic ready, push, pop, load_h, load_s;
  assign in_e = {bus.regWrtm, bus.memWrtm, bus.rsltSrcm, bus.readDm, bus.pc4m, bus.ujWrtBckm, bus.rdm};
  assign push = bus.validm & ready;
  assign pop = (state != EMPTY) & bus.readyw;
  // ready is registered from the next state so it never depends on readyw combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      ready <= 1'b0;
    end else begin
      state <= nxt;
      ready <= nxt != TWO;
    end
  end
  always_comb begin
    nxt = bus.flush ? EMPTY :
          state == EMPTY ? (push ? ONE : EMPTY) :
          state == ONE ? (push == pop ? ONE : (push ? TWO : EMPTY)) :
          (pop ? ONE : TWO);
    load_h = !bus.flush & (state == EMPTY ? push : state == ONE ? (push & pop) : pop);
    load_s = !bus.flush & (state == ONE) & push & !pop;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      s <= '0;
    end else begin
      if (load_h) h <= (state == TWO) ? s : in_e;
      if (load_s) s <= in_e;
    end
  end
  always_comb begin
    bus.readym = ready;
    bus.validw = state != EMPTY;
    bus.regWrtw = h.regwrt & (state != EMPTY);
    bus.memWrtw = h.memwrt & (state != EMPTY);
    bus.rsltSrcw = h.rslt;
    bus.readDw = h.readd;
    bus.pc4w = h.pc4;
    bus.ujWrtBckw = h.ujw;
    bus.rdw = h.rd;
    bus.wbDataw = h.rslt[1:0] == 2'b00 ? h.ujw :
                  h.rslt[1:0] == 2'b01 ? h.readd :
                  h.rslt[1:0] == 2'b10 ? h.pc4 : '0;
  end
`ifdef MEWB_RETIRE_CNT_EN
  // a pop during flush still counts: WB consumed that entry
  always_ff @(posedge clk) begin
    if (rst) retireCnt <= '0;
    else if (pop & (h.regwrt | h.memwrt)) retireCnt <= retireCnt + 64'd1;
  end
`endif
endmodule

// File: tb/tb_mewb_stage.sv
// tb_mewb_stage: queue-model checker plus directed vectors for mewb_stage
module tb_mewb_stage;
  typedef struct packed {
    logic rw;
    logic mw;
    logic [1:0] rs;
    logic [31:0] rdd;
    logic [31:0] pc;
    logic [31:0] uj;
    logic [4:0] rd;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mewb_if #(.XLEN(32), .REGW(5), .RSLTW(2)) bus ();
  logic [63:0] retire_cnt;
`ifdef MEWB_RETIRE_CNT_EN
  mewb_stage #(.XLEN(32), .REGW(5), .RSLTW(2)) dut (.clk(clk), .rst(rst), .bus(bus), .retireCnt(retire_cnt));
`else
  mewb_stage #(.XLEN(32), .REGW(5), .RSLTW(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign retire_cnt = '0;
`endif
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  ent_t q[$];
  bit m_ready = 1'b0;
  bit armed = 1'b0;
  longint unsigned m_ret = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask
  function automatic logic [31:0] wb(input ent_t e);
    case (e.rs)
      2'b00: return e.uj;
      2'b01: return e.rdd;
      2'b10: return e.pc;
      default: return 32'h0;
    endcase
  endfunction
  always @(posedge clk) begin
    bit pu, po;
    if (rst) begin
      q.delete();
      m_ready = 1'b0;
      m_ret = 0;
      armed = 1'b1;
    end else begin
      pu = bus.validm & m_ready;
      po = (q.size() > 0) & bus.readyw;
      if (po) begin
        if (q[0].rw | q[0].mw) m_ret++;
        void'(q.pop_front());
      end
      if (bus.flush) q.delete();
      else if (pu) q.push_back({bus.regWrtm, bus.memWrtm, bus.rsltSrcm, bus.readDm, bus.pc4m, bus.ujWrtBckm, bus.rdm});
      m_ready = q.size() < 2;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("m_validw", bus.validw, q.size() > 0);
      chk("m_readym", bus.readym, m_ready);
      if (q.size() > 0) begin
        chk("m_regWrtw", bus.regWrtw, q[0].rw);
        chk("m_memWrtw", bus.memWrtw, q[0].mw);
        chk("m_rdw", bus.rdw, q[0].rd);
        chk("m_rsltSrcw", bus.rsltSrcw, q[0].rs);
        chk("m_readDw", bus.readDw, q[0].rdd);
        chk("m_pc4w", bus.pc4w, q[0].pc);
        chk("m_ujWrtBckw", bus.ujWrtBckw, q[0].uj);
        chk("m_wbDataw", bus.wbDataw, wb(q[0]));
      end else begin
        chk("m_regWrtw_idle", bus.regWrtw, 0);
        chk("m_memWrtw_idle", bus.memWrtw, 0);
      end
`ifdef MEWB_RETIRE_CNT_EN
      chk("m_retireCnt", retire_cnt, m_ret);
`endif
    end
  end
  task automatic ent(input logic [4:0] rd, input logic [1:0] rs, input logic rw, input logic mw,
                     input logic [31:0] rdd, input logic [31:0] pc, input logic [31:0] uj);
    bus.rdm = rd;
    bus.rsltSrcm = rs;
    bus.regWrtm = rw;
    bus.memWrtm = mw;
    bus.readDm = rdd;
    bus.pc4m = pc;
    bus.ujWrtBckm = uj;
  endtask
  task automatic cyc(input logic v, input logic rdy, input logic fl);
    bus.validm = v;
    bus.readyw = rdy;
    bus.flush = fl;
    @(negedge clk);
  endtask
  initial begin
    bus.validm = 0;
    bus.readyw = 0;
    bus.flush = 0;
    ent(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_validw", bus.validw, 0);
    chk("rst_regWrtw", bus.regWrtw, 0);
    chk("rst_wbDataw", bus.wbDataw, 0);
    chk("rst_readym", bus.readym, 0);
    rst = 0;
    cyc(0, 0, 0);
    chk("post_rst_readym", bus.readym, 1);
    for (int i = 1; i <= 4; i++) begin
      ent(5'(i), 2'b01, 1, 0, 32'hA0 + 32'(i), 32'h0, 32'h0);
      cyc(1, 1, 0);
      chk("stream_validw", bus.validw, 1);
      chk("stream_rdw", bus.rdw, i);
      chk("stream_wbDataw", bus.wbDataw, 64'hA0 + 64'(i));
      chk("stream_readym", bus.readym, 1);
    end
    cyc(0, 1, 0);
    chk("stream_drain_validw", bus.validw, 0);
    ent(5, 2'b00, 1, 0, 32'h0, 32'h0, 32'h55);
    cyc(1, 0, 0);
    chk("bp_x_rdw", bus.rdw, 5);
    chk("bp_x_readym", bus.readym, 1);
    ent(6, 2'b00, 1, 0, 32'h0, 32'h0, 32'h66);
    cyc(1, 0, 0);
    chk("bp_full_readym", bus.readym, 0);
    chk("bp_full_rdw", bus.rdw, 5);
    cyc(0, 0, 0);
    chk("bp_hold_rdw", bus.rdw, 5);
    chk("bp_hold_wbDataw", bus.wbDataw, 32'h55);
    cyc(0, 1, 0);
    chk("bp_y_rdw", bus.rdw, 6);
    chk("bp_y_readym", bus.readym, 1);
    cyc(0, 1, 0);
    chk("bp_drain_validw", bus.validw, 0);
    ent(7, 2'b00, 1, 0, 0, 0, 32'h77);
    cyc(1, 0, 0);
    ent(8, 2'b00, 1, 0, 0, 0, 32'h88);
    cyc(1, 0, 0);
    chk("fl_full_readym", bus.readym, 0);
    ent(9, 2'b00, 1, 0, 0, 0, 32'h99);
    cyc(1, 0, 1);
    chk("fl_validw", bus.validw, 0);
    chk("fl_regWrtw", bus.regWrtw, 0);
    chk("fl_readym", bus.readym, 1);
    cyc(0, 1, 0);
    chk("fl_no9_validw", bus.validw, 0);
    ent(10, 2'b00, 1, 0, 32'h33, 32'h22, 32'h11);
    cyc(1, 0, 0);
    chk("mux00", bus.wbDataw, 32'h11);
    ent(11, 2'b10, 1, 0, 32'h33, 32'h22, 32'h11);
    cyc(1, 1, 0);
    chk("mux10", bus.wbDataw, 32'h22);
    ent(12, 2'b11, 1, 1, 32'h33, 32'h22, 32'h11);
    cyc(1, 1, 0);
    chk("mux11", bus.wbDataw, 32'h0);
    chk("mux11_rdw", bus.rdw, 12);
    cyc(0, 1, 0);
    chk("inv_validw", bus.validw, 0);
    chk("inv_regWrtw", bus.regWrtw, 0);
    chk("inv_memWrtw", bus.memWrtw, 0);
`ifdef MEWB_RETIRE_CNT_EN
    for (int i = 0; i < 4; i++) begin
      ent(5'(13 + i), 2'b00, i < 3, 0, 0, 0, 32'(i));
      cyc(1, 1, 0);
    end
    cyc(0, 1, 0);
    chk("retire_after_pops", retire_cnt, 12);
    cyc(0, 0, 1);
    chk("retire_after_flush", retire_cnt, 12);
`endif
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
